// File: rtl/forwarding_pkg.sv
// Shared types and defaults for the EX-stage forwarding / load-use hazard unit.
//   fwd_entry_t     : one in-flight register write tracked after EX
//   FWD_SEL_RF      : bypass select meaning "use the register-file value"
//   FWD_*_DEF       : default tracker depth and first load-forwardable entry
//   FWD_REGW_MAX    : widest register index a tracker entry can hold
package forwarding_pkg;

  localparam int unsigned FWD_NSTAGES_DEF    = 3;
  localparam int unsigned FWD_LOAD_READY_DEF = 1;
  localparam int unsigned FWD_SEL_RF         = 0;

  // Entries carry a fixed-width destination so the struct can live in a
  // package; narrower register indices are zero-extended on entry.
  localparam int unsigned FWD_REGW_MAX = 8;

  typedef struct packed {
    logic                    valid;
    logic                    regWr;
    logic                    memRd;
    logic [FWD_REGW_MAX-1:0] regDst;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// EX-side bus of the forwarding / hazard unit.
//   master : pipeline side -- drives the EX instruction fields, freeze and
//            flush; receives bypass selects, stall request and stall count
//   slave  : the hazard unit itself
//   ex_src holds NSRC operands, operand i at [i*REGW +: REGW];
//   fwd_sel holds NSRC selects, operand i at [i*SELW +: SELW].
interface fwd_hazard_unit_if #(
  parameter int unsigned NSRC = 2,
  parameter int unsigned REGW = 5,
  parameter int unsigned SELW = 2
);

  logic                 ex_regWr;
  logic [REGW-1:0]      ex_regDst;
  logic                 ex_memRd;
  logic [NSRC*REGW-1:0] ex_src;
  logic                 pipe_freeze;
  logic                 ex_flush;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 hazard_stall;
  logic [31:0]          stall_cnt;

  modport master (
    output ex_regWr, ex_regDst, ex_memRd, ex_src, pipe_freeze, ex_flush,
    input  fwd_sel, hazard_stall, stall_cnt
  );

  modport slave (
    input  ex_regWr, ex_regDst, ex_memRd, ex_src, pipe_freeze, ex_flush,
    output fwd_sel, hazard_stall, stall_cnt
  );

endinterface

// File: rtl/fwd_tracker.sv
// Shift register of in-flight register writes, one entry per post-EX stage
// (entry 0 = MEM, entry 1 = WB, ...).
//   CLK           : clock, rising edge
//   RST           : synchronous active-high reset, clears every entry
//   shift_en      : advance the pipeline image; low holds every entry
//   insert_bubble : load an invalid entry into slot 0 instead of ex_entry
//   ex_entry      : description of the instruction currently in EX
//   entries       : registered tracker contents
module fwd_tracker
  import forwarding_pkg::*;
#(
  parameter int unsigned NSTAGES = FWD_NSTAGES_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       shift_en,
  input  logic       insert_bubble,
  input  fwd_entry_t ex_entry,
  output fwd_entry_t entries [NSTAGES]
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned k = 0; k < NSTAGES; k++) begin
        entries[k] <= '0;
      end
    end else if (shift_en) begin
      entries[0] <= insert_bubble ? '0 : ex_entry;
      for (int unsigned k = 1; k < NSTAGES; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the pipelined MIPS datapath.
// Sits beside EX: tracks in-flight register writes, drives one bypass select
// per EX source operand and requests a stall when a load result is not yet
// forwardable.
//   CLK, RST               : clock and synchronous active-high reset
//   bus.ex_regWr/regDst/memRd : EX instruction write/destination/load flags
//   bus.ex_src             : EX source registers
//   bus.pipe_freeze        : global hold, tracker keeps its contents
//   bus.ex_flush           : EX instruction squashed, becomes a bubble
//   bus.fwd_sel            : per operand, 0 = register file, k = tracker entry k-1
//   bus.hazard_stall       : hold IF/ID/EX and bubble into MEM
//   bus.stall_cnt          : saturating count of stall cycles
module fwd_hazard_unit
  import forwarding_pkg::*;
#(
  parameter int unsigned NSTAGES    = FWD_NSTAGES_DEF,
  parameter int unsigned NSRC       = 2,
  parameter int unsigned REGW       = 5,
  parameter int unsigned LOAD_READY = FWD_LOAD_READY_DEF
) (
  input logic              CLK,
  input logic              RST,
  fwd_hazard_unit_if.slave bus
);

  localparam int unsigned SELW = $clog2(NSTAGES + 1);

  fwd_entry_t              entries [NSTAGES];
  fwd_entry_t              ex_entry;
  logic [NSRC*NSTAGES-1:0] match;
  logic [NSRC*NSTAGES-1:0] load_use;
  logic                    hazard_stall;
  logic [31:0]             stall_cnt;

  always_comb begin
    ex_entry                   = '0;
    ex_entry.valid             = 1'b1;
    ex_entry.regWr             = bus.ex_regWr;
    ex_entry.memRd             = bus.ex_memRd;
    ex_entry.regDst[REGW-1:0]  = bus.ex_regDst;
  end

  // A stalled EX instruction must not enter MEM; a flushed one never existed.
  fwd_tracker #(
    .NSTAGES (NSTAGES)
  ) u_tracker (
    .CLK           (CLK),
    .RST           (RST),
    .shift_en      (!bus.pipe_freeze),
    .insert_bubble (hazard_stall || bus.ex_flush),
    .ex_entry      (ex_entry),
    .entries       (entries)
  );

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [FWD_REGW_MAX-1:0] src_ext;
    logic [SELW-1:0]         sel;

    always_comb begin
      src_ext            = '0;
      src_ext[REGW-1:0]  = bus.ex_src[i*REGW +: REGW];
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
      // r0 is hard-wired zero and never has a producer worth forwarding.
      assign match[i*NSTAGES + k] = entries[k].valid && entries[k].regWr &&
                                    (entries[k].regDst != '0) &&
                                    (entries[k].regDst == src_ext);

      if (k < LOAD_READY) begin : g_early
        assign load_use[i*NSTAGES + k] = match[i*NSTAGES + k] && entries[k].memRd;
      end else begin : g_late
        assign load_use[i*NSTAGES + k] = 1'b0;
      end
    end

    // Walk oldest to youngest so the youngest matching producer is the last
    // assignment and therefore wins.
    always_comb begin
      sel = SELW'(FWD_SEL_RF);
      for (int unsigned k = NSTAGES; k > 0; k--) begin
        if (match[i*NSTAGES + k - 1]) begin
          sel = SELW'(k);
        end
      end
    end

    assign bus.fwd_sel[i*SELW +: SELW] = sel;
  end

  assign hazard_stall     = !bus.ex_flush && (|load_use);
  assign bus.hazard_stall = hazard_stall;

  // Counts during freeze too: the stall is still being asserted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (hazard_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NSRC(2), .REGW(5), .SELW(2)) if_a ();
  fwd_hazard_unit_if #(.NSRC(3), .REGW(5), .SELW(3)) if_b ();

  fwd_hazard_unit #(.NSTAGES(3), .NSRC(2), .REGW(5), .LOAD_READY(1)) dut_a (
    .CLK (clk),
    .RST (rst),
    .bus (if_a)
  );

  fwd_hazard_unit #(.NSTAGES(4), .NSRC(3), .REGW(5), .LOAD_READY(2)) dut_b (
    .CLK (clk),
    .RST (rst),
    .bus (if_b)
  );

  typedef struct {
    string       tag;
    logic [8:0]  sel;
    logic        stall;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_one(input string tag, input string what,
                           input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, got, want);
    end
  endtask

  task automatic sb_underflow(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s.scoreboard observed=empty expected=entry", tag);
  endtask

  // Drive one EX cycle on the default instance, queue what it must show,
  // compare at the falling edge, then let the rising edge advance state.
  task automatic step_a(input string tag, input logic r,
                        input logic wr, input logic [4:0] dst, input logic rd,
                        input logic [4:0] s0, input logic [4:0] s1,
                        input logic frz, input logic fl,
                        input logic [1:0] e0, input logic [1:0] e1,
                        input logic est, input logic [31:0] ecnt);
    exp_t e;
    rst                = r;
    if_a.ex_regWr      = wr;
    if_a.ex_regDst     = dst;
    if_a.ex_memRd      = rd;
    if_a.ex_src        = {s1, s0};
    if_a.pipe_freeze   = frz;
    if_a.ex_flush      = fl;
    sb_a.push_back('{tag, 9'({e1, e0}), est, ecnt});
    @(negedge clk);
    if (sb_a.size() == 0) begin
      sb_underflow(tag);
    end else begin
      e = sb_a.pop_front();
      check_one(e.tag, "sel",   32'(if_a.fwd_sel),      32'(e.sel));
      check_one(e.tag, "stall", 32'(if_a.hazard_stall), 32'(e.stall));
      check_one(e.tag, "cnt",   if_a.stall_cnt,         e.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input string tag,
                        input logic wr, input logic [4:0] dst, input logic rd,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] e0, input logic [2:0] e1, input logic [2:0] e2,
                        input logic est, input logic [31:0] ecnt);
    exp_t e;
    if_b.ex_regWr      = wr;
    if_b.ex_regDst     = dst;
    if_b.ex_memRd      = rd;
    if_b.ex_src        = {s2, s1, s0};
    if_b.pipe_freeze   = 1'b0;
    if_b.ex_flush      = 1'b0;
    sb_b.push_back('{tag, {e2, e1, e0}, est, ecnt});
    @(negedge clk);
    if (sb_b.size() == 0) begin
      sb_underflow(tag);
    end else begin
      e = sb_b.pop_front();
      check_one(e.tag, "sel",   32'(if_b.fwd_sel),      32'(e.sel));
      check_one(e.tag, "stall", 32'(if_b.hazard_stall), 32'(e.stall));
      check_one(e.tag, "cnt",   if_b.stall_cnt,         e.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst              = 1'b1;
    if_a.ex_regWr    = 1'b0;
    if_a.ex_regDst   = '0;
    if_a.ex_memRd    = 1'b0;
    if_a.ex_src      = '0;
    if_a.pipe_freeze = 1'b0;
    if_a.ex_flush    = 1'b0;
    if_b.ex_regWr    = 1'b0;
    if_b.ex_regDst   = '0;
    if_b.ex_memRd    = 1'b0;
    if_b.ex_src      = '0;
    if_b.pipe_freeze = 1'b0;
    if_b.ex_flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //            tag    rst wr dst rd s0 s1 frz fl  sel0 sel1 stall cnt
    step_a("A0",  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // reset state
    step_a("A1",  0, 1, 3, 0, 1, 2, 0, 0,  0, 0, 0, 0);   // add r3
    step_a("A2",  0, 0, 0, 0, 3, 0, 0, 0,  1, 0, 0, 0);   // r3 from MEM
    step_a("A3",  0, 0, 0, 0, 3, 0, 0, 0,  2, 0, 0, 0);   // r3 from WB
    step_a("A4",  0, 0, 0, 0, 0, 3, 0, 0,  0, 3, 0, 0);   // r3 from WB+1 on src1
    step_a("A5",  0, 1, 6, 0, 0, 0, 0, 0,  0, 0, 0, 0);   // add r6
    step_a("A6",  0, 1, 6, 0, 6, 6, 0, 0,  1, 1, 0, 0);   // add r6 again
    step_a("A7",  0, 0, 0, 0, 6, 6, 0, 0,  1, 1, 0, 0);   // youngest producer wins
    step_a("A8",  0, 0, 0, 0, 6, 0, 0, 0,  2, 0, 0, 0);
    step_a("A9",  0, 1, 4, 1, 0, 0, 0, 0,  0, 0, 0, 0);   // lw r4
    step_a("A10", 0, 0, 0, 0, 0, 4, 0, 0,  0, 1, 1, 0);   // load-use stall
    step_a("A11", 0, 0, 0, 0, 0, 4, 0, 0,  0, 2, 0, 1);   // load now in WB
    step_a("A12", 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);   // write r0
    step_a("A13", 0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 1);   // lw r0, r0 never forwards
    step_a("A14", 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);   // no stall on r0 load
    step_a("A15", 0, 1, 5, 1, 0, 0, 0, 0,  0, 0, 0, 1);   // lw r5
    step_a("A16", 0, 0, 0, 0, 5, 0, 1, 0,  1, 0, 1, 1);   // frozen, stall held
    step_a("A17", 0, 0, 0, 0, 5, 0, 1, 0,  1, 0, 1, 2);
    step_a("A18", 0, 0, 0, 0, 5, 0, 1, 0,  1, 0, 1, 3);
    step_a("A19", 0, 0, 0, 0, 5, 0, 0, 0,  1, 0, 1, 4);   // unfrozen, bubble inserted
    step_a("A20", 0, 0, 0, 0, 5, 0, 0, 0,  2, 0, 0, 5);
    step_a("A21", 0, 1, 7, 1, 0, 0, 0, 0,  0, 0, 0, 5);   // lw r7
    step_a("A22", 0, 0, 0, 0, 7, 0, 0, 1,  1, 0, 0, 5);   // flush suppresses stall
    step_a("A23", 0, 0, 0, 0, 7, 0, 0, 0,  2, 0, 0, 5);
    step_a("A24", 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 5);   // fill tracker r1,r2,r3
    step_a("A25", 0, 1, 2, 0, 1, 0, 0, 0,  1, 0, 0, 5);
    step_a("A26", 0, 1, 3, 0, 1, 2, 0, 0,  2, 1, 0, 5);
    step_a("A27", 1, 0, 0, 0, 1, 3, 0, 0,  3, 1, 0, 5);   // reset asserted
    step_a("A28", 0, 0, 0, 0, 1, 3, 0, 0,  0, 0, 0, 0);   // all cleared

    if_a.ex_regWr = 1'b0;
    if_a.ex_memRd = 1'b0;
    if_a.ex_src   = '0;

    //            tag   wr dst rd s0 s1 s2  sel0 sel1 sel2 stall cnt
    step_b("B0",  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step_b("B1",  1, 9, 1, 0, 0, 0,  0, 0, 0, 0, 0);       // lw r9
    step_b("B2",  0, 0, 0, 0, 0, 9,  0, 0, 1, 1, 0);       // first bubble
    step_b("B3",  0, 0, 0, 0, 0, 9,  0, 0, 2, 1, 1);       // second bubble
    step_b("B4",  0, 0, 0, 0, 0, 9,  0, 0, 3, 0, 2);       // forwardable
    step_b("B5",  0, 0, 0, 9, 9, 9,  4, 4, 4, 0, 2);       // deepest entry

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
